oled_spi_rx: RTL and testbench
==============================

OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth applied to every SPI-side input.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports i_sclk, i_sdin, i_cs, i_dc, i_reset  input  1 each  serial clock (idles high), data, chip select (active-low), data/command select (1 = data), display reset (active-low).
REQ-005 SHALL have port o_byte  output  8  last received byte.
REQ-006 SHALL have port o_byte_valid  output  1  one-cycle strobe for o_byte.
REQ-007 SHALL have port o_byte_is_data  output  1  the dc value latched with o_byte.
REQ-008 SHALL have ports o_fb_we (1), o_fb_addr (10), o_fb_wdata (8)  outputs  framebuffer write port; addr = page*128 + column.
REQ-009 SHALL have ports o_display_on (1), o_invert (1), o_contrast (8), o_addr_mode (2)  outputs  decoded controller state.

Function
REQ-010 SHALL pass i_sclk, i_sdin, i_cs, i_dc and i_reset through identical SYNC_STAGES-flop synchronizers so that all five inputs stay mutually aligned.
REQ-011 SHALL detect a rising sclk edge when the synchronized sclk is 1 and its previous value was 0, and SHALL only act on it while the synchronized cs is 0.
REQ-012 SHALL shift the synchronized sdin in MSB first on each detected edge, using a 3-bit bit counter.
REQ-013 SHALL sample dc on the edge that carries the 8th bit.
REQ-014 SHALL register o_byte and o_byte_is_data, and SHALL pulse o_byte_valid for exactly one cycle, on the clk cycle after the 8th edge is detected.
REQ-015 SHALL work for sclk high and low phases of 1 or more clk cycles when sclk is driven from clk, and 2 or more when it is asynchronous.
REQ-016 SHALL clear the bit counter and discard any partial byte while the synchronized cs is 1; it SHALL NOT raise o_byte_valid for that byte.
REQ-017 SHALL implement the command decoder FSM states IDLE, ARG1, ARG2A, ARG2B:
- IDLE: take an opcode.
- ARG1: one argument pending.
- ARG2A / ARG2B: first / second argument of a two-argument command pending.
REQ-018 In IDLE, SHALL decode single-byte opcodes as follows; unknown opcodes are ignored and the FSM stays in IDLE:
- 0xAE / 0xAF: display_on = 0 / 1.
- 0xA6 / 0xA7: invert = 0 / 1.
- 0xA4, 0xA5, 0x40-0x7F, 0xA0, 0xA1, 0xC0, 0xC8: accepted with no effect.
REQ-019 SHALL treat 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDB and 0x8D as one-argument opcodes (go to ARG1):
- 0x81: the argument sets contrast.
- 0x20: the argument's [1:0] sets addr_mode.
- All others: the argument is consumed and discarded.
REQ-020 SHALL treat 0x21 (column start, end) and 0x22 (page start, end) as two-argument opcodes:
- Column values are taken mod 128 and page values mod 8.
- Completing either command SHALL also load the current pointer with the new start value.
REQ-021 SHALL return the FSM to IDLE after the final argument byte.
REQ-022 SHALL hold the FSM state unchanged across cs deassertion, so arguments may arrive in a later cs frame.
REQ-023 SHALL handle every data byte (dc = 1) in any FSM state the same way, without changing the FSM state:
- Write the byte at the current pointer: o_fb_we, addr and wdata in the same cycle as o_byte_valid.
- Then advance the pointer.
REQ-024 SHALL advance the pointer using the horizontal rule, regardless of addr_mode:
- If column == col_end: column = col_start and the page advances; otherwise column + 1.
- If the page advances and page == page_end: page = page_start; otherwise page + 1.
REQ-025 SHALL make command effects visible on the outputs one cycle after o_byte_valid.
REQ-026 SHALL, while the synchronized i_reset is 0, synchronously restore every reset value of REQ-027 except o_byte, drop any partial byte, and ignore sclk.

Reset
REQ-027 SHALL, on rst, asynchronously set:
- FSM = IDLE, bit counter = 0.
- o_byte = 0, o_byte_valid = 0, o_byte_is_data = 0.
- o_fb_we = 0, o_fb_addr = 0, o_fb_wdata = 0.
- display_on = 0, invert = 0, contrast = 0x7F, addr_mode = 0.
- col_start = 0, col_end = 127, page_start = 0, page_end = 7, pointer = (page 0, column 0).
REQ-028 SHALL clear all synchronizer flops to their idle values on rst: sclk = 1, cs = 1, i_reset = 1, others 0.

Verification
REQ-029 Bench SHALL drive cs = 0, dc = 0 and send the 23-byte init stream (0xAE ... 0xAF) with 1-cycle sclk phases -> exactly 23 o_byte_valid pulses, contrast = 0x7F, addr_mode = 0, display_on = 1, no o_fb_we.
REQ-030 Bench SHALL send 1024 data bytes of value n mod 256 -> o_fb_addr 0..1023 in order with matching wdata, then the 1025th write at addr 0.
REQ-031 Bench SHALL send 0x21,10,12 then 0x22,2,3 and 7 data bytes -> addresses 266, 267, 268, 394, 395, 396, 266.
REQ-032 Bench SHALL raise cs after 5 bits, then send 0xA7 -> only 0xA7 is reported and invert = 1.
REQ-033 Bench SHALL send 0x81, deassert cs for 10 cycles, then send 0x33 -> contrast = 0x33; a data byte 0x55 sent between 0x81 and 0x33 is written to the framebuffer and contrast is still 0x33.
REQ-034 Bench SHALL pulse i_reset low for 4 cycles and assert rst mid-byte -> every output returns to its REQ-027 value and the next full byte is received correctly.

Source files
------------

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: SPI slave receiver with SSD1306-style command decoder and framebuffer write port
// Ports:
//   clk, rst            system clock, async active-high reset
//   i_sclk, i_sdin      SPI clock (idles high) and data, asynchronous to clk
//   i_cs, i_dc, i_reset chip select (low), data/command (1 = data), display reset (low)
//   o_byte, o_byte_valid, o_byte_is_data   last received byte, 1-cycle strobe, latched dc
//   o_fb_we, o_fb_addr, o_fb_wdata         framebuffer write, addr = page*128 + column
//   o_display_on, o_invert, o_contrast, o_addr_mode   decoded controller state
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sclk,
    input  logic       i_sdin,
    input  logic       i_cs,
    input  logic       i_dc,
    input  logic       i_reset,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_byte_is_data,
    output logic       o_fb_we,
    output logic [9:0] o_fb_addr,
    output logic [7:0] o_fb_wdata,
    output logic       o_display_on,
    output logic       o_invert,
    output logic [7:0] o_contrast,
    output logic [1:0] o_addr_mode
);
    // packed as {sclk, sdin, cs, dc, reset}; idle levels keep the link quiet out of reset
    localparam logic [4:0] SYNC_IDLE = 5'b10101;
    localparam logic [1:0] IDLE = 2'd0, ARG1 = 2'd1, ARG2A = 2'd2, ARG2B = 2'd3;

    logic [4:0] sync_q [SYNC_STAGES];
    logic       sclk_s, sdin_s, cs_s, dc_s, reset_s, sclk_prev, rise;
    logic [2:0] bit_cnt;
    logic [6:0] shift_q;
    logic [7:0] rx_byte;
    logic [1:0] state, state_nx;
    logic [7:0] cmd;
    logic [6:0] arg0;
    logic       cmd_v, one_arg, two_arg;
    logic       set_disp, set_inv, set_con, set_mode, set_col, set_page;
    logic [6:0] col, col_start, col_end;
    logic [2:0] page, page_start, page_end;

    assign {sclk_s, sdin_s, cs_s, dc_s, reset_s} = sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev & ~cs_s & reset_s;
    assign rx_byte = {shift_q, sdin_s};
    // commands are decoded from the registered byte, one cycle behind the strobe
    assign cmd_v   = o_byte_valid & ~o_byte_is_data;
    assign one_arg = o_byte inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D};
    assign two_arg = o_byte inside {8'h21, 8'h22};

    // all five inputs share one chain so they stay mutually aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= SYNC_IDLE;
            sclk_prev <= 1'b1;
        end else begin
            sync_q[0] <= {i_sclk, i_sdin, i_cs, i_dc, i_reset};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!reset_s) state_nx = IDLE;
        else if (cmd_v)
            case (state)
                IDLE:    state_nx = one_arg ? ARG1 : two_arg ? ARG2A : IDLE;
                ARG2A:   state_nx = ARG2B;
                default: state_nx = IDLE;
            endcase
    end

    // 0xAE/0xAF and 0xA6/0xA7 differ only in bit 0, which carries the new value
    always_comb begin
        set_disp = cmd_v && state == IDLE && o_byte[7:1] == 7'h57;
        set_inv  = cmd_v && state == IDLE && o_byte[7:1] == 7'h53;
        set_con  = cmd_v && state == ARG1 && cmd == 8'h81;
        set_mode = cmd_v && state == ARG1 && cmd == 8'h20;
        set_col  = cmd_v && state == ARG2B && cmd == 8'h21;
        set_page = cmd_v && state == ARG2B && cmd == 8'h22;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0; shift_q <= '0; cmd <= '0; arg0 <= '0;
            o_byte <= '0; o_byte_valid <= 1'b0; o_byte_is_data <= 1'b0;
            o_fb_we <= 1'b0; o_fb_addr <= '0; o_fb_wdata <= '0;
            o_display_on <= 1'b0; o_invert <= 1'b0; o_contrast <= 8'h7F; o_addr_mode <= '0;
            col_start <= '0; col_end <= 7'd127; page_start <= '0; page_end <= 3'd7;
            col <= '0; page <= '0;
        end else if (!reset_s) begin
            bit_cnt <= '0; shift_q <= '0; cmd <= '0; arg0 <= '0;
            o_byte_valid <= 1'b0; o_byte_is_data <= 1'b0;
            o_fb_we <= 1'b0; o_fb_addr <= '0; o_fb_wdata <= '0;
            o_display_on <= 1'b0; o_invert <= 1'b0; o_contrast <= 8'h7F; o_addr_mode <= '0;
            col_start <= '0; col_end <= 7'd127; page_start <= '0; page_end <= 3'd7;
            col <= '0; page <= '0;
        end else begin
            o_byte_valid <= 1'b0;
            o_fb_we <= 1'b0;
            if (cs_s) bit_cnt <= '0;
            else if (rise) begin
                shift_q <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_byte <= rx_byte;
                    o_byte_valid <= 1'b1;
                    o_byte_is_data <= dc_s;
                    if (dc_s) begin
                        o_fb_we <= 1'b1;
                        o_fb_addr <= {page, col};
                        o_fb_wdata <= rx_byte;
                        if (col == col_end) begin
                            col <= col_start;
                            page <= (page == page_end) ? page_start : page + 3'd1;
                        end else col <= col + 7'd1;
                    end
                end
            end
            if (cmd_v && state == IDLE) cmd <= o_byte;
            if (cmd_v && state == ARG2A) arg0 <= o_byte[6:0];
            if (set_disp) o_display_on <= o_byte[0];
            if (set_inv) o_invert <= o_byte[0];
            if (set_con) o_contrast <= o_byte;
            if (set_mode) o_addr_mode <= o_byte[1:0];
            if (set_col) begin
                col_start <= arg0;
                col_end <= o_byte[6:0];
                col <= arg0;
            end
            if (set_page) begin
                page_start <= arg0[2:0];
                page_end <= o_byte[2:0];
                page <= arg0[2:0];
            end
        end
    end
endmodule

// File: tb/tb_oled_spi_rx.sv
// tb_oled_spi_rx: directed and randomized checks of oled_spi_rx against a command-queue reference model
module tb_oled_spi_rx;
    logic       clk = 1'b0, rst = 1'b1;
    logic       sclk = 1'b1, sdin = 1'b0, cs = 1'b1, dc = 1'b0, ireset = 1'b1;
    logic [7:0] o_byte, o_fb_wdata, o_contrast;
    logic       o_byte_valid, o_byte_is_data, o_fb_we, o_display_on, o_invert;
    logic [9:0] o_fb_addr;
    logic [1:0] o_addr_mode;

    always #5 clk = ~clk;

    oled_spi_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_sclk(sclk), .i_sdin(sdin), .i_cs(cs), .i_dc(dc), .i_reset(ireset),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_byte_is_data(o_byte_is_data),
        .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_wdata(o_fb_wdata),
        .o_display_on(o_display_on), .o_invert(o_invert), .o_contrast(o_contrast),
        .o_addr_mode(o_addr_mode)
    );

    int n_assert = 0, n_fail = 0;
    logic [17:0] got_wq[$], exp_wq[$];
    logic [8:0]  got_bq[$], exp_bq[$];
    logic [7:0]  pend[$];
    logic        m_disp, m_inv;
    logic [7:0]  m_con, m_last;
    logic [1:0]  m_mode;
    int          m_col, m_page, m_cs, m_ce, m_ps, m_pe;
    logic [7:0]  init_seq [23] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                   8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'h81, 8'h7F,
                                   8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0]  cmd_tab [12] = '{8'h81, 8'h20, 8'h21, 8'h22, 8'hAE, 8'hAF, 8'hA6, 8'hA7,
                                  8'hA4, 8'h40, 8'hC8, 8'h8D};
    int          exp_addr31 [7] = '{266, 267, 268, 394, 395, 396, 266};

    always @(posedge clk) begin
        #1;
        if (o_byte_valid) got_bq.push_back({o_byte_is_data, o_byte});
        if (o_fb_we) got_wq.push_back({o_fb_addr, o_fb_wdata});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nargs(input logic [7:0] op);
        if (op inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D}) return 1;
        if (op inside {8'h21, 8'h22}) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_inv = 0; m_con = 8'h7F; m_mode = 0;
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
        pend.delete();
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        logic [9:0] a;
        exp_bq.push_back({d, b});
        m_last = b;
        if (d) begin
            a = 10'(m_page * 128 + m_col);
            exp_wq.push_back({a, b});
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else m_col = (m_col + 1) % 128;
        end else begin
            pend.push_back(b);
            if (pend.size() == nargs(pend[0]) + 1) begin
                case (pend[0])
                    8'hAE: m_disp = 0;
                    8'hAF: m_disp = 1;
                    8'hA6: m_inv = 0;
                    8'hA7: m_inv = 1;
                    8'h81: m_con = pend[1];
                    8'h20: m_mode = pend[1][1:0];
                    8'h21: begin m_cs = pend[1] % 128; m_ce = pend[2] % 128; m_col = m_cs; end
                    8'h22: begin m_ps = pend[1] % 8; m_pe = pend[2] % 8; m_page = m_ps; end
                    default: ;
                endcase
                pend.delete();
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int ph);
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 0; sdin = b[i];
            repeat (ph) @(negedge clk);
            sclk = 1;
            repeat (ph) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b, input int ph);
        dc = d;
        send_bits(b, 8, ph);
        model_byte(d, b);
    endtask

    task automatic drain();
        repeat (10) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_display_on"}, 32'(o_display_on), 32'(m_disp));
        chk({tag, "_invert"}, 32'(o_invert), 32'(m_inv));
        chk({tag, "_contrast"}, 32'(o_contrast), 32'(m_con));
        chk({tag, "_addr_mode"}, 32'(o_addr_mode), 32'(m_mode));
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nbytes"}, got_bq.size(), exp_bq.size());
        foreach (exp_bq[i]) if (i < got_bq.size()) chk({tag, "_byte"}, 32'(got_bq[i]), 32'(exp_bq[i]));
        chk({tag, "_nwrites"}, got_wq.size(), exp_wq.size());
        foreach (exp_wq[i]) if (i < got_wq.size()) chk({tag, "_write"}, 32'(got_wq[i]), 32'(exp_wq[i]));
        got_bq.delete(); exp_bq.delete(); got_wq.delete(); exp_wq.delete();
    endtask

    task automatic check_reset_outputs(input string tag, input logic [7:0] byte_exp);
        chk({tag, "_byte"}, 32'(o_byte), 32'(byte_exp));
        chk({tag, "_valid"}, 32'(o_byte_valid), 0);
        chk({tag, "_is_data"}, 32'(o_byte_is_data), 0);
        chk({tag, "_fb_we"}, 32'(o_fb_we), 0);
        chk({tag, "_fb_addr"}, 32'(o_fb_addr), 0);
        chk({tag, "_fb_wdata"}, 32'(o_fb_wdata), 0);
        chk({tag, "_display_on"}, 32'(o_display_on), 0);
        chk({tag, "_invert"}, 32'(o_invert), 0);
        chk({tag, "_contrast"}, 32'(o_contrast), 32'h7F);
        chk({tag, "_addr_mode"}, 32'(o_addr_mode), 0);
    endtask

    initial begin
        logic       d;
        logic [7:0] b;
        model_reset();
        m_last = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset", 8'h00);

        // init stream, all commands
        cs = 0;
        repeat (2) @(negedge clk);
        foreach (init_seq[i]) send_byte(0, init_seq[i], 1);
        drain();
        chk("init_pulses", got_bq.size(), 23);
        chk("init_no_fb_we", got_wq.size(), 0);
        chk("init_contrast", 32'(o_contrast), 32'h7F);
        chk("init_addr_mode", 32'(o_addr_mode), 0);
        chk("init_display_on", 32'(o_display_on), 1);
        check_state("init");
        check_logs("init");

        // full framebuffer sweep, then wrap to address 0
        for (int n = 0; n < 1024; n++) send_byte(1, 8'(n), 1);
        drain();
        chk("fill_nwrites", got_wq.size(), 1024);
        foreach (got_wq[i]) chk("fill_addr_data", 32'(got_wq[i]), 32'({10'(i), 8'(i)}));
        check_logs("fill");
        send_byte(1, 8'hC3, 1);
        drain();
        chk("wrap_nwrites", got_wq.size(), 1);
        if (got_wq.size() > 0) chk("wrap_addr", 32'(got_wq[0][17:8]), 0);
        check_logs("wrap");

        // column/page window
        send_byte(0, 8'h21, 1); send_byte(0, 8'd10, 1); send_byte(0, 8'd12, 1);
        send_byte(0, 8'h22, 1); send_byte(0, 8'd2, 1); send_byte(0, 8'd3, 1);
        for (int n = 0; n < 7; n++) send_byte(1, 8'($urandom), 1);
        drain();
        chk("window_nwrites", got_wq.size(), 7);
        foreach (got_wq[i]) if (i < 7) chk("window_addr", 32'(got_wq[i][17:8]), exp_addr31[i]);
        check_logs("window");

        // partial byte aborted by cs
        dc = 0;
        send_bits(8'hAE, 5, 1);
        cs = 1;
        repeat (6) @(negedge clk);
        cs = 0;
        repeat (2) @(negedge clk);
        send_byte(0, 8'hA7, 1);
        drain();
        chk("abort_nbytes", got_bq.size(), 1);
        if (got_bq.size() > 0) chk("abort_byte", 32'(got_bq[0]), 32'h0A7);
        chk("abort_invert", 32'(o_invert), 1);
        check_logs("abort");

        // argument in a later cs frame, data byte in between
        send_byte(0, 8'h81, 1);
        cs = 1;
        repeat (10) @(negedge clk);
        cs = 0;
        repeat (2) @(negedge clk);
        send_byte(1, 8'h55, 2);
        send_byte(0, 8'h33, 1);
        drain();
        chk("split_contrast", 32'(o_contrast), 32'h33);
        chk("split_nwrites", got_wq.size(), 1);
        if (got_wq.size() > 0) chk("split_wdata", 32'(got_wq[0][7:0]), 32'h55);
        check_state("split");
        check_logs("split");

        // randomized mix of commands, arguments and data with varying sclk phases
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 15; n++) begin
                d = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 2) != 0) ? cmd_tab[$urandom_range(0, 11)] : 8'($urandom);
                send_byte(d, b, $urandom_range(1, 3));
            end
            drain();
            check_state("random");
            check_logs("random");
        end

        // display reset pin: state cleared, o_byte kept, pending argument dropped
        send_byte(0, 8'hAF, 1);
        send_byte(0, 8'hA7, 1);
        send_byte(0, 8'h81, 1);
        drain();
        check_state("pre_ireset");
        check_logs("pre_ireset");
        ireset = 0;
        repeat (4) @(negedge clk);
        ireset = 1;
        drain();
        model_reset();
        check_reset_outputs("ireset", m_last);
        send_byte(0, 8'hA7, 1);
        send_byte(1, 8'h99, 1);
        drain();
        chk("ireset_fsm_idle_contrast", 32'(o_contrast), 32'h7F);
        chk("ireset_fsm_idle_invert", 32'(o_invert), 1);
        if (got_wq.size() > 0) chk("ireset_ptr_addr", 32'(got_wq[0][17:8]), 0);
        check_logs("ireset");

        // async rst mid-byte
        dc = 0;
        send_bits(8'hAF, 4, 1);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        model_reset();
        check_reset_outputs("rst_mid", 8'h00);
        chk("rst_mid_nbytes", got_bq.size(), 0);
        got_bq.delete(); got_wq.delete();
        send_byte(0, 8'hAF, 1);
        drain();
        chk("rst_next_byte", 32'(o_byte), 32'hAF);
        chk("rst_next_display_on", 32'(o_display_on), 1);
        check_state("rst_next");
        check_logs("rst_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
